// File: rtl/traffic_monitor.sv
// traffic_monitor: watches the lamp outputs of a traffic-light controller and flags
// illegal patterns, out-of-order transitions and patterns held for too long.
//
// Parameters
//   MAX_DWELL  consecutive samples one pattern may be held before a stuck fault
// Ports
//   clk        single clock, all state on the rising edge
//   rst        synchronous active-high reset
//   red/amber/green  lamp inputs, sampled every rising edge
//   state      monitor state: 0=SYNC 1=T_R 2=T_RA 3=T_G 4=T_A (registered)
//   err_pulse  one-cycle fault strobe
//   err        sticky fault flag, cleared only by rst
//   err_count  saturating fault count
//   seq_count  wrapping count of completed R->RA->G->A->R cycles
module traffic_monitor #(
  parameter int unsigned MAX_DWELL = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       red,
  input  logic       amber,
  input  logic       green,
  output logic [2:0] state,
  output logic       err_pulse,
  output logic       err,
  output logic [3:0] err_count,
  output logic [7:0] seq_count
);

  typedef enum logic [2:0] {
    StSync     = 3'd0,
    StRed      = 3'd1,
    StRedAmber = 3'd2,
    StGreen    = 3'd3,
    StAmber    = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] dwell_q, dwell_d;
  // Set once a stuck fault has been raised for the current hold; cleared on pattern change.
  logic       stuck_q, stuck_d;
  logic       err_pulse_q, err_q;
  logic [3:0] err_count_q;
  logic [7:0] seq_count_q;

  logic [2:0] pattern;
  logic       legal;
  state_e     pat_state;
  state_e     next_legal;
  logic       fault;
  logic       seq_inc;

  assign pattern = {red, amber, green};

  // Map the sampled pattern onto the state it represents.
  always_comb begin
    legal     = 1'b1;
    pat_state = StSync;
    unique case (pattern)
      3'b100:  pat_state = StRed;
      3'b110:  pat_state = StRedAmber;
      3'b001:  pat_state = StGreen;
      3'b010:  pat_state = StAmber;
      default: legal = 1'b0;
    endcase
  end

  // Expected successor of the current state in the R->RA->G->A->R cycle.
  always_comb begin
    next_legal = StSync;
    unique case (state_q)
      StRed:      next_legal = StRedAmber;
      StRedAmber: next_legal = StGreen;
      StGreen:    next_legal = StAmber;
      StAmber:    next_legal = StRed;
      default:    next_legal = StSync;
    endcase
  end

  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    stuck_d = stuck_q;
    fault   = 1'b0;
    seq_inc = 1'b0;
    if (!legal) begin
      fault   = 1'b1;
      state_d = StSync;
      dwell_d = 8'd0;
      stuck_d = 1'b0;
    end else if (state_q == StSync) begin
      state_d = pat_state;
      dwell_d = 8'd1;
      stuck_d = 1'b0;
    end else if (pat_state == state_q) begin
      if (dwell_q != 8'hFF) dwell_d = dwell_q + 8'd1;
      // Compare the dwell before this sample: the (MAX_DWELL+1)th hold is the stuck one.
      if (32'(dwell_q) >= MAX_DWELL && !stuck_q) begin
        fault   = 1'b1;
        stuck_d = 1'b1;
      end
    end else begin
      // Either the proper successor or an out-of-order resync; both land on the pattern.
      state_d = pat_state;
      dwell_d = 8'd1;
      stuck_d = 1'b0;
      if (pat_state == next_legal) begin
        seq_inc = (state_q == StAmber);
      end else begin
        fault = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StSync;
      dwell_q     <= 8'd0;
      stuck_q     <= 1'b0;
      err_pulse_q <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= 4'd0;
      seq_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      dwell_q     <= dwell_d;
      stuck_q     <= stuck_d;
      err_pulse_q <= fault;
      err_q       <= err_q | fault;
      if (fault && err_count_q != 4'hF) err_count_q <= err_count_q + 4'd1;
      if (seq_inc) seq_count_q <= seq_count_q + 8'd1;
    end
  end

  assign state     = state_q;
  assign err_pulse = err_pulse_q;
  assign err       = err_q;
  assign err_count = err_count_q;
  assign seq_count = seq_count_q;

endmodule

// File: tb/tb_traffic_monitor.sv
// Self-checking bench for traffic_monitor: directed scenarios plus randomized lamp
// patterns, each cycle compared against a behavioural model of the monitor rules.
module tb_traffic_monitor;

  localparam int MaxDwell = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       red = 1'b0, amber = 1'b0, green = 1'b0;
  logic [2:0] state;
  logic       err_pulse, err;
  logic [3:0] err_count;
  logic [7:0] seq_count;

  int total = 0;
  int bad   = 0;

  traffic_monitor #(.MAX_DWELL(MaxDwell)) dut (
    .clk       (clk),
    .rst       (rst),
    .red       (red),
    .amber     (amber),
    .green     (green),
    .state     (state),
    .err_pulse (err_pulse),
    .err       (err),
    .err_count (err_count),
    .seq_count (seq_count)
  );

  always #5 clk = ~clk;

  // Reference model state: position in the light cycle (0 = unsynchronised, 1..4 = R,RA,G,A).
  int m_pos = 0, m_dwell = 0, m_stuck = 0;
  int m_pulse = 0, m_err = 0, m_errs = 0, m_seq = 0;
  int order[4] = '{4, 6, 1, 2};  // R, RA, G, A as {red,amber,green}

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model(input int pat, input bit r);
    int idx;
    bit f;
    if (r) begin
      m_pos = 0; m_dwell = 0; m_stuck = 0; m_pulse = 0; m_err = 0; m_errs = 0; m_seq = 0;
      return;
    end
    idx = 0;
    for (int k = 0; k < 4; k++) if (order[k] == pat) idx = k + 1;
    f = 0;
    if (idx == 0) begin
      f = 1; m_pos = 0; m_dwell = 0;
    end else if (m_pos == 0) begin
      m_pos = idx; m_dwell = 1; m_stuck = 0;
    end else if (idx == m_pos) begin
      if (m_dwell >= MaxDwell && m_stuck == 0) begin f = 1; m_stuck = 1; end
      m_dwell = (m_dwell < 255) ? m_dwell + 1 : 255;
    end else begin
      if (idx == (m_pos % 4) + 1) begin
        if (m_pos == 4) m_seq = (m_seq + 1) % 256;
      end else f = 1;
      m_pos = idx; m_dwell = 1; m_stuck = 0;
    end
    m_pulse = f;
    if (f) begin
      m_err = 1;
      if (m_errs < 15) m_errs++;
    end
  endtask

  // Apply one sample, advance the model, then compare every output 1 ns after the edge.
  task automatic step(input int pat, input bit r);
    rst = r;
    {red, amber, green} = 3'(pat);
    @(posedge clk);
    model(pat, r);
    #1;
    check("state", int'(state), m_pos);
    check("err_pulse", int'(err_pulse), m_pulse);
    check("err", int'(err), m_err);
    check("err_count", int'(err_count), m_errs);
    check("seq_count", int'(seq_count), m_seq);
  endtask

  initial begin
    int exp_st[5] = '{1, 2, 3, 4, 1};
    int pulses, pulse_at, cur, pat, r;

    // Reset state.
    step(0, 1'b1);
    step(0, 1'b1);
    check("rst_state", int'(state), 0);
    check("rst_err_count", int'(err_count), 0);

    // One full legal cycle.
    for (int i = 0; i < 5; i++) begin
      step(order[i % 4], 1'b0);
      check("seq_state", int'(state), exp_st[i]);
    end
    check("seq_one", int'(seq_count), 1);
    check("seq_noerr", int'(err), 0);

    // R then G: out-of-order resync.
    step(4, 1'b0);
    step(1, 1'b0);
    check("ooo_pulse", int'(err_pulse), 1);
    check("ooo_state", int'(state), 3);
    check("ooo_count", int'(err_count), 1);
    // Illegal from T_G, then amber resyncs without a new fault.
    step(7, 1'b0);
    check("ill_pulse", int'(err_pulse), 1);
    check("ill_state", int'(state), 0);
    step(2, 1'b0);
    check("resync_state", int'(state), 4);
    check("resync_nopulse", int'(err_pulse), 0);
    check("resync_count", int'(err_count), 2);

    // Stuck red: one fault, seen after the 16th sample.
    step(0, 1'b1);
    pulses = 0; pulse_at = 0;
    for (int i = 1; i <= 20; i++) begin
      step(4, 1'b0);
      if (err_pulse) begin pulses++; pulse_at = i; end
    end
    check("stuck_pulses", pulses, 1);
    check("stuck_at", pulse_at, 16);
    check("stuck_count", int'(err_count), 1);

    // Saturate the fault counter, then wrap the sequence counter.
    step(0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      cur = $urandom_range(0, 3);
      step((cur == 0) ? 0 : (cur == 1) ? 3 : (cur == 2) ? 5 : 7, 1'b0);
    end
    check("sat_count", int'(err_count), 15);
    step(4, 1'b0);
    for (int i = 0; i < 256; i++) begin
      step(6, 1'b0); step(1, 1'b0); step(2, 1'b0); step(4, 1'b0);
    end
    check("wrap_seq", int'(seq_count), 0);
    check("wrap_errs", int'(err_count), 15);

    // Reset mid-sequence in T_G with err set, concurrent with an illegal pattern.
    step(0, 1'b1);
    step(4, 1'b0); step(6, 1'b0); step(1, 1'b0); step(2, 1'b0); step(4, 1'b0); step(1, 1'b0);
    check("pre_rst_err", int'(err), 1);
    check("pre_rst_seq", int'(seq_count), 1);
    step(7, 1'b1);
    check("mid_rst_state", int'(state), 0);
    check("mid_rst_err", int'(err), 0);
    check("mid_rst_pulse", int'(err_pulse), 0);
    check("mid_rst_seq", int'(seq_count), 0);

    // Randomized traffic: mostly legal progress, some holds, junk, resets and long stalls.
    cur = 0;
    for (int i = 0; i < 2500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 55) begin
        cur = (cur + 1) % 4; pat = order[cur];
      end else if (r < 75) begin
        pat = order[cur];
      end else if (r < 85) begin
        pat = $urandom_range(0, 7);
      end else if (r < 93) begin
        cur = $urandom_range(0, 3); pat = order[cur];
      end else if (r < 96) begin
        for (int k = 0; k < 18; k++) step(order[cur], 1'b0);
        pat = order[cur];
      end else begin
        step(order[cur], 1'b1);
        pat = order[cur];
      end
      step(pat, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
